// File: rtl/ioctl_dispatch_pkg.sv
// ioctl_dispatch_pkg: shared FSM state type and default ioctl index assignments
package ioctl_dispatch_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STRETCH} state_t;
  localparam int ROM_INDEX_DEF      = 0;
  localparam int MOD_BASE_INDEX_DEF = 1;
  localparam int DIP_INDEX_DEF      = 254;
endpackage

// File: rtl/ioctl_reset_stretch.sv
// ioctl_reset_stretch: down-counter that holds the core in reset for CYCLES cycles after a ROM load
//   clk_sys, reset : clock and synchronous active-high reset
//   start          : one-cycle pulse on the cycle the load finishes
//   done           : high on the last stretch cycle
module ioctl_reset_stretch #(
  parameter int CYCLES = 256
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic start,
  output logic done
);
  localparam int W = CYCLES > 0 ? $clog2(CYCLES + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk_sys) begin
    if (reset) cnt <= '0;
    else if (start) cnt <= W'(CYCLES);
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign done = cnt == W'(1);
endmodule

// File: rtl/ioctl_dispatch.sv
// ioctl_dispatch: routes HPS ioctl bytes to ROM regions, DIP and mod registers, and sequences core reset
//   ioctl_*      : HPS download interface; ioctl_wait stalls the HPS while a ROM byte is pending
//   rom_*        : one-hot per-region ROM write port with per-region ready
//   dip_sw       : DIP bytes, byte n at [8n+7:8n]
//   mod_reg      : mod bytes, byte n at [8n+7:8n]
//   core_reset   : held during reset, load and the post-load stretch
//   dl_done      : one-cycle pulse when a ROM load finishes
//   dl_checksum  : byte sum of completed ROM writes of the last load
//   dl_dropped   : saturating count of rejected ROM bytes of the last load
module ioctl_dispatch
  import ioctl_dispatch_pkg::*;
#(
  parameter int ADDR_W         = 25,
  parameter int REGIONS        = 4,
  parameter int REGION_AW      = 16,
  parameter int DIP_BYTES      = 8,
  parameter int DIP_INDEX      = DIP_INDEX_DEF,
  parameter int MOD_COUNT      = 2,
  parameter int MOD_BASE_INDEX = MOD_BASE_INDEX_DEF,
  parameter int ROM_INDEX      = ROM_INDEX_DEF,
  parameter int STRETCH_CYCLES = 256
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic [REGIONS-1:0]     rom_wr,
  output logic [REGION_AW-1:0]   rom_addr,
  output logic [7:0]             rom_data,
  input  logic [REGIONS-1:0]     rom_ready,
  output logic [DIP_BYTES*8-1:0] dip_sw,
  output logic [MOD_COUNT*8-1:0] mod_reg,
  output logic                   core_reset,
  output logic                   dl_done,
  output logic [7:0]             dl_checksum,
  output logic [15:0]            dl_dropped
);
  localparam int RW = ADDR_W - REGION_AW;
  localparam int IW = REGIONS > 1 ? $clog2(REGIONS) : 1;
  state_t                 state, next;
  logic [RW-1:0]          region;
  logic                   rom_hit, capture, drop, complete, load_entry, stretch_start, stretch_done;
  logic                   pend_v;
  logic [IW-1:0]          pend_r;
  logic [REGION_AW-1:0]   pend_addr;
  logic [7:0]             pend_data, cksum;
  logic [15:0]            dropped;
  logic [DIP_BYTES*8-1:0] dip_q = '0;
  logic [MOD_COUNT*8-1:0] mod_q = '0;
  assign region   = ioctl_addr[ADDR_W-1:REGION_AW];
  assign rom_hit  = state == LOAD && ioctl_wr && ioctl_index == 8'(ROM_INDEX);
  // A byte arriving while the buffer is occupied is dropped even if it completes this cycle.
  assign capture  = rom_hit && 32'(region) < REGIONS && !pend_v;
  assign drop     = rom_hit && !capture;
  assign complete = pend_v && rom_ready[pend_r];
  always_comb begin
    next = state;
    if (state == IDLE && ioctl_download && ioctl_index == 8'(ROM_INDEX)) next = LOAD;
    if (state == LOAD && !ioctl_download && !pend_v && !rom_hit) next = STRETCH_CYCLES == 0 ? IDLE : STRETCH;
    if (state == STRETCH && stretch_done) next = IDLE;
  end
  assign load_entry    = state == IDLE && next == LOAD;
  assign stretch_start = state == LOAD && next == STRETCH;
  ioctl_reset_stretch #(.CYCLES(STRETCH_CYCLES)) u_stretch (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (stretch_start),
    .done    (stretch_done)
  );
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      pend_v    <= 1'b0;
      pend_r    <= '0;
      pend_addr <= '0;
      pend_data <= '0;
      cksum     <= '0;
      dropped   <= '0;
    end else begin
      state <= next;
      if (capture) begin
        pend_v    <= 1'b1;
        pend_r    <= IW'(region);
        pend_addr <= ioctl_addr[REGION_AW-1:0];
        pend_data <= ioctl_dout;
      end else if (complete) pend_v <= 1'b0;
      if (load_entry) begin
        cksum   <= '0;
        dropped <= '0;
      end else begin
        if (complete) cksum <= cksum + pend_data;
        if (drop && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
      end
    end
  end
  // DIP and mod registers ignore reset so settings survive a core reset.
  always_ff @(posedge clk_sys) begin
    for (int n = 0; n < DIP_BYTES; n++)
      if (ioctl_wr && ioctl_index == 8'(DIP_INDEX) && ioctl_addr == ADDR_W'(n)) dip_q[8*n +: 8] <= ioctl_dout;
    for (int n = 0; n < MOD_COUNT; n++)
      if (ioctl_wr && ioctl_index == 8'(MOD_BASE_INDEX + n)) mod_q[8*n +: 8] <= ioctl_dout;
  end
  assign ioctl_wait  = pend_v && !reset;
  assign rom_wr      = (pend_v && !reset) ? REGIONS'(1) << pend_r : '0;
  assign rom_addr    = reset ? '0 : pend_addr;
  assign rom_data    = reset ? '0 : pend_data;
  assign dl_checksum = reset ? '0 : cksum;
  assign dl_dropped  = reset ? '0 : dropped;
  assign dl_done     = !reset && state == LOAD && next != LOAD;
  assign core_reset  = reset || state != IDLE;
  assign dip_sw      = dip_q;
  assign mod_reg     = mod_q;
endmodule

// File: tb/tb_ioctl_dispatch.sv
// tb_ioctl_dispatch: scoreboard bench for ioctl_dispatch with directed ROM, DIP, mod and reset vectors
module tb_ioctl_dispatch;
  logic        clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = '0, ioctl_dout = '0;
  logic [24:0] ioctl_addr = '0;
  logic [3:0]  rom_ready = 4'hF;
  logic        ioctl_wait, core_reset, dl_done;
  logic [3:0]  rom_wr;
  logic [15:0] rom_addr, dl_dropped, mod_reg;
  logic [7:0]  rom_data, dl_checksum;
  logic [63:0] dip_sw;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [3:0] wr; logic [15:0] addr; logic [7:0] data;} rom_t;
  typedef struct packed {logic [7:0] ck; logic [15:0] dr;} done_t;
  rom_t  rom_q[$];
  done_t done_q[$];
  rom_t  me;
  done_t md;
  always #5 clk_sys = ~clk_sys;
  ioctl_dispatch dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ready(rom_ready),
    .dip_sw(dip_sw), .mod_reg(mod_reg), .core_reset(core_reset), .dl_done(dl_done),
    .dl_checksum(dl_checksum), .dl_dropped(dl_dropped)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic settle_wait();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (!ioctl_wait) break;
    end
    chk("wait release", ioctl_wait, 0);
  endtask
  task automatic rom_byte(input logic [24:0] a, input logic [7:0] d, input logic [3:0] exp_wr);
    if (exp_wr != 0) rom_q.push_back({exp_wr, a[15:0], d});
    tick();
    ioctl_index = 8'd0;
    ioctl_wr    = 1'b1;
    ioctl_addr  = a;
    ioctl_dout  = d;
    tick();
    ioctl_wr = 1'b0;
    settle_wait();
  endtask
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_sys);
      seen = dl_done;
    end
    chk("dl_done seen", seen, 1);
  endtask
  always @(negedge clk_sys) begin
    if ((rom_wr & rom_ready) != 0) begin
      if (rom_q.size() == 0) chk("unexpected rom write", rom_wr, 0);
      else begin
        me = rom_q.pop_front();
        chk("rom_wr", rom_wr, me.wr);
        chk("rom_addr", rom_addr, me.addr);
        chk("rom_data", rom_data, me.data);
      end
    end
    if (dl_done) begin
      if (done_q.size() == 0) chk("unexpected dl_done", dl_done, 0);
      else begin
        md = done_q.pop_front();
        chk("dl_checksum", dl_checksum, md.ck);
        chk("dl_dropped", dl_dropped, md.dr);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    @(negedge clk_sys);
    chk("reset core_reset", core_reset, 1);
    chk("reset ioctl_wait", ioctl_wait, 0);
    chk("reset rom_wr", rom_wr, 0);
    chk("reset dl_done", dl_done, 0);
    chk("reset checksum", dl_checksum, 0);
    chk("reset dropped", dl_dropped, 0);
    chk("powerup dip_sw", dip_sw, 0);
    chk("powerup mod_reg", mod_reg, 0);
    tick();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("idle core_reset", core_reset, 0);
    tick();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    for (int i = 0; i < 4; i++) rom_byte(25'(i), 8'(i + 1), 4'b0001);
    done_q.push_back({8'h0A, 16'h0000});
    tick();
    ioctl_download = 1'b0;
    wait_done();
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      if (!core_reset) break;
      cnt++;
    end
    chk("stretch cycles", cnt, 256);
    tick();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    rom_q.push_back({4'b0010, 16'h0005, 8'h77});
    tick();
    rom_ready  = 4'b1101;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h10005;
    ioctl_dout = 8'h77;
    tick();
    ioctl_wr = 1'b0;
    repeat (5) begin
      @(negedge clk_sys);
      chk("stall wait", ioctl_wait, 1);
      chk("stall rom_wr", rom_wr, 4'b0010);
      chk("stall rom_addr", rom_addr, 16'h0005);
    end
    tick();
    rom_ready = 4'hF;
    @(negedge clk_sys);
    chk("completion wait", ioctl_wait, 1);
    @(negedge clk_sys);
    chk("after completion wait", ioctl_wait, 0);
    rom_byte(25'h40000, 8'hEE, 4'b0000);
    chk("oor dropped", dl_dropped, 1);
    chk("oor checksum", dl_checksum, 8'h77);
    chk("oor rom_wr", rom_wr, 0);
    rom_q.push_back({4'b0100, 16'h0001, 8'h10});
    tick();
    rom_ready  = 4'h0;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h20001;
    ioctl_dout = 8'h10;
    tick();
    ioctl_addr = 25'h20002;
    ioctl_dout = 8'h55;
    tick();
    ioctl_wr  = 1'b0;
    rom_ready = 4'hF;
    settle_wait();
    chk("full dropped", dl_dropped, 2);
    chk("full checksum", dl_checksum, 8'h87);
    done_q.push_back({8'h87, 16'h0002});
    tick();
    ioctl_download = 1'b0;
    wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      if (!core_reset) break;
    end
    chk("idle after stretch", core_reset, 0);
    chk("checksum holds", dl_checksum, 8'h87);
    tick();
    ioctl_index = 8'd254;
    ioctl_addr  = 25'd2;
    ioctl_dout  = 8'h5A;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("dip byte2", dip_sw[23:16], 8'h5A);
    chk("dip no wait", ioctl_wait, 0);
    tick();
    ioctl_index = 8'd2;
    ioctl_dout  = 8'h33;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("mod byte1", mod_reg[15:8], 8'h33);
    tick();
    ioctl_index = 8'd1;
    ioctl_dout  = 8'h11;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_dout = 8'h22;
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("mod last wins", mod_reg[7:0], 8'h22);
    tick();
    ioctl_index = 8'd254;
    ioctl_addr  = 25'd8;
    ioctl_dout  = 8'hFF;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("dip oor ignored", dip_sw, 64'h0000_0000_005A_0000);
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("dip survives reset", dip_sw, 64'h0000_0000_005A_0000);
    chk("mod survives reset", mod_reg, 16'h3322);
    tick();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_addr     = 25'd0;
    tick();
    rom_ready  = 4'h0;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd3;
    ioctl_dout = 8'h99;
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("pending before reset", ioctl_wait, 1);
    tick();
    reset          = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("post reset wait", ioctl_wait, 0);
    chk("post reset rom_wr", rom_wr, 0);
    chk("post reset idle", core_reset, 0);
    tick();
    rom_ready = 4'hF;
    repeat (5) @(negedge clk_sys);
    tick();
    ioctl_index = 8'd0;
    ioctl_addr  = 25'd7;
    ioctl_dout  = 8'h12;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("idle rom write no wait", ioctl_wait, 0);
    chk("idle rom write not counted", dl_dropped, 0);
    chk("idle rom write no load", core_reset, 0);
    repeat (3) @(negedge clk_sys);
    chk("rom queue drained", rom_q.size(), 0);
    chk("done queue drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
